// File: rtl/mul_engine.sv
// Memory-mapped signed 16x16 multiplier: reads operands from BASE+1..4, writes product to BASE+5..8.
// Radix-2 Booth by default; define MUL_ENGINE_RADIX4_EN for the radix-4 Booth datapath.
//
// state | meaning
// IDLE  | waiting for a high->low transition on start
// RD    | fetching A[15:8], A[7:0], B[15:8], B[7:0] from BASE+1..BASE+4
// MUL   | Booth iterations on the accumulator
// WR    | writing P[31:24]..P[7:0] to BASE+5..BASE+8
// DONE  | done high until start is seen high again
module mul_engine #(
    parameter int              AW   = 8,
    parameter logic [AW-1:0]   BASE = '0
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    output logic          busy
);

`ifdef MUL_ENGINE_RADIX4_EN
    localparam int N = 8;
`else
    localparam int N = 16;
`endif
    localparam logic [3:0] MUL_LAST = 4'(N - 1);

    typedef enum logic [2:0] {IDLE, RD, MUL, WR, DONE} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        start_q;
    logic        launch;
    logic [15:0] op_a, op_b;
    logic [15:0] b_sr;
    logic        b_prev;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] addend;

    assign launch = start_q && !start;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            start_q <= start;
        end
    end

    // cnt is a down-counter; each busy state ends when it reaches zero
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        busy        = 1'b0;
        done        = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = BASE;
        mem_wr_data = '0;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nx = RD;
                    cnt_nx   = 4'd3;
                end
            end
            RD: begin
                busy     = 1'b1;
                mem_addr = BASE + AW'(4'd4 - cnt);
                if (start) begin
                    state_nx = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nx = MUL;
                    cnt_nx   = MUL_LAST;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (start) begin
                    state_nx = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nx = WR;
                    cnt_nx   = 4'd3;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            WR: begin
                busy        = 1'b1;
                mem_wr_en   = 1'b1;
                mem_addr    = BASE + AW'(4'd8 - cnt);
                mem_wr_data = acc[{cnt[1:0], 3'b000} +: 8];
                if (start) begin
                    state_nx = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef MUL_ENGINE_RADIX4_EN
    always_comb begin
        addend = '0;
        case ({b_sr[1:0], b_prev})
            3'b001, 3'b010: addend = mcand;
            3'b011:         addend = mcand << 1;
            3'b100:         addend = -(mcand << 1);
            3'b101, 3'b110: addend = -mcand;
            default:        addend = '0;
        endcase
    end
`else
    always_comb begin
        addend = '0;
        case ({b_sr[0], b_prev})
            2'b01:   addend = mcand;
            2'b10:   addend = -mcand;
            default: addend = '0;
        endcase
    end
`endif

    // The multiplicand shifts left instead of the accumulator shifting right,
    // so the product is exact modulo 2^32 without a guard bit.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            op_a   <= '0;
            op_b   <= '0;
            b_sr   <= '0;
            b_prev <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
        end else begin
            case (state)
                RD: begin
                    case (cnt[1:0])
                        2'd3: op_a[15:8] <= mem_rd_data;
                        2'd2: op_a[7:0]  <= mem_rd_data;
                        2'd1: op_b[15:8] <= mem_rd_data;
                        default: begin
                            op_b[7:0] <= mem_rd_data;
                            b_sr      <= {op_b[15:8], mem_rd_data};
                            b_prev    <= 1'b0;
                            mcand     <= {{16{op_a[15]}}, op_a};
                            acc       <= '0;
                        end
                    endcase
                end
                MUL: begin
                    acc <= acc + addend;
`ifdef MUL_ENGINE_RADIX4_EN
                    mcand  <= mcand << 2;
                    b_sr   <= {{2{b_sr[15]}}, b_sr[15:2]};
                    b_prev <= b_sr[1];
`else
                    mcand  <= mcand << 1;
                    b_sr   <= {b_sr[15], b_sr[15:1]};
                    b_prev <= b_sr[0];
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_engine.sv
// Directed bench for mul_engine: two instances (BASE=00 and BASE=FC) each with its own byte memory.
module tb_mul_engine;

`ifdef MUL_ENGINE_RADIX4_EN
    localparam int N = 8;
`else
    localparam int N = 16;
`endif
    localparam int DE = 8 + N;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start0, start1;
    logic       done0, done1, busy0, busy1, we0, we1;
    logic [7:0] addr0, addr1, wd0, wd1, rd0, rd1;
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic       tb_we = 1'b0;
    logic       tb_sel = 1'b0;
    logic [7:0] tb_addr = 8'h00, tb_data = 8'h00;
    int         stb0 = 0, stb1 = 0;
    int         tests_run = 0, fails = 0;

    mul_engine #(.AW(8), .BASE(8'h00)) u_dut0 (
        .CLK(clk), .reset_n(reset_n), .start(start0), .done(done0),
        .mem_addr(addr0), .mem_rd_data(rd0), .mem_wr_en(we0),
        .mem_wr_data(wd0), .busy(busy0)
    );

    mul_engine #(.AW(8), .BASE(8'hFC)) u_dut1 (
        .CLK(clk), .reset_n(reset_n), .start(start1), .done(done1),
        .mem_addr(addr1), .mem_rd_data(rd1), .mem_wr_en(we1),
        .mem_wr_data(wd1), .busy(busy1)
    );

    assign rd0 = mem0[addr0];
    assign rd1 = mem1[addr1];

    always @(posedge clk) begin
        if (we0) begin
            mem0[addr0] <= wd0;
            stb0 <= stb0 + 1;
        end else if (tb_we && !tb_sel) begin
            mem0[tb_addr] <= tb_data;
        end
        if (we1) begin
            mem1[addr1] <= wd1;
            stb1 <= stb1 + 1;
        end else if (tb_we && tb_sel) begin
            mem1[tb_addr] <= tb_data;
        end
    end

    task automatic poke(input logic sel, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_sel = sel; tb_addr = a; tb_data = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic load_ops(input logic sel, input logic [7:0] base,
                            input logic [15:0] a, input logic [15:0] b);
        logic [7:0] ad;
        ad = base + 8'd1; poke(sel, ad, a[15:8]);
        ad = base + 8'd2; poke(sel, ad, a[7:0]);
        ad = base + 8'd3; poke(sel, ad, b[15:8]);
        ad = base + 8'd4; poke(sel, ad, b[7:0]);
    endtask

    task automatic fill_res(input logic sel, input logic [7:0] base, input logic [7:0] d);
        logic [7:0] ad;
        for (int i = 5; i <= 8; i++) begin
            ad = base + 8'(i);
            poke(sel, ad, d);
        end
    endtask

    function automatic logic [31:0] result(input logic sel, input logic [7:0] base);
        logic [7:0] a5, a6, a7, a8;
        a5 = base + 8'd5; a6 = base + 8'd6; a7 = base + 8'd7; a8 = base + 8'd8;
        if (sel) return {mem1[a5], mem1[a6], mem1[a7], mem1[a8]};
        return {mem0[a5], mem0[a6], mem0[a7], mem0[a8]};
    endfunction

    task automatic set_start(input logic sel, input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    // Edge k is the k-th rising edge after start fell; edge 0 launches the operation.
    task automatic run_op(input logic sel, output int de, output int wfirst,
                          output int nstr, output logic b0);
        de = -1; wfirst = -1; nstr = 0; b0 = 1'b0;
        @(negedge clk); set_start(sel, 1'b1);
        @(negedge clk); set_start(sel, 1'b0);
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (k == 0) b0 = sel ? busy1 : busy0;
            if (sel ? we1 : we0) begin
                nstr++;
                if (wfirst < 0) wfirst = k;
            end
            if (sel ? done1 : done0) begin
                de = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        tb_we = 1'b0; start0 = 1'b0; start1 = 1'b0;
        reset_n = 1'b0;
        #2;
        tests_run++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy0); end
        tests_run++; if (done0 !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done0); end
        tests_run++; if (we0 !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b want 0", we0); end
        tests_run++; if (addr0 !== 8'h00) begin fails++; $display("FAIL reset_addr0 got %h want 00", addr0); end
        tests_run++; if (wd0 !== 8'h00) begin fails++; $display("FAIL reset_wr_data got %h want 00", wd0); end
        tests_run++; if (addr1 !== 8'hFC) begin fails++; $display("FAIL reset_addr1 got %h want fc", addr1); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (busy0 !== 1'b0) begin fails++; $display("FAIL idle_after_reset busy got %b want 0", busy0); end
    endtask

    task automatic test_basic;
        int de, wf, ns, s; logic b0;
        load_ops(1'b0, 8'h00, 16'h03FF, 16'hFFFB);
        fill_res(1'b0, 8'h00, 8'h00);
        s = stb0;
        run_op(1'b0, de, wf, ns, b0);
        tests_run++; if (b0 !== 1'b1) begin fails++; $display("FAIL basic_busy_edge0 got %b want 1", b0); end
        tests_run++; if (de != DE) begin fails++; $display("FAIL basic_latency got %0d want %0d", de, DE); end
        tests_run++; if (wf != DE - 4) begin fails++; $display("FAIL basic_wr_window got %0d want %0d", wf, DE - 4); end
        tests_run++; if (ns != 4) begin fails++; $display("FAIL basic_wr_cycles got %0d want 4", ns); end
        tests_run++; if (stb0 - s != 4) begin fails++; $display("FAIL basic_strobes got %0d want 4", stb0 - s); end
        tests_run++; if (result(1'b0, 8'h00) !== 32'hFFFFEC05) begin fails++; $display("FAIL basic_product got %h want ffffec05", result(1'b0, 8'h00)); end
        tests_run++; if (busy0 !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done got %b want 0", busy0); end
    endtask

    task automatic test_corners;
        int de, wf, ns; logic b0;
        load_ops(1'b0, 8'h00, 16'h8000, 16'h8000);
        run_op(1'b0, de, wf, ns, b0);
        tests_run++; if (result(1'b0, 8'h00) !== 32'h40000000) begin fails++; $display("FAIL min_x_min got %h want 40000000", result(1'b0, 8'h00)); end
        load_ops(1'b0, 8'h00, 16'h8000, 16'h7FFF);
        run_op(1'b0, de, wf, ns, b0);
        tests_run++; if (result(1'b0, 8'h00) !== 32'hC0008000) begin fails++; $display("FAIL min_x_max got %h want c0008000", result(1'b0, 8'h00)); end
        tests_run++; if (de != DE) begin fails++; $display("FAIL corner_latency got %0d want %0d", de, DE); end
    endtask

    task automatic test_zero;
        int de, wf, ns, s; logic b0;
        load_ops(1'b0, 8'h00, 16'h0000, 16'h1234);
        fill_res(1'b0, 8'h00, 8'hAA);
        s = stb0;
        run_op(1'b0, de, wf, ns, b0);
        tests_run++; if (result(1'b0, 8'h00) !== 32'h00000000) begin fails++; $display("FAIL zero_product got %h want 00000000", result(1'b0, 8'h00)); end
        tests_run++; if (stb0 - s != 4) begin fails++; $display("FAIL zero_strobes got %0d want 4", stb0 - s); end
    endtask

    task automatic test_reset_mid;
        int de, wf, ns, s; logic b0;
        load_ops(1'b0, 8'h00, 16'h03FF, 16'hFFFB);
        fill_res(1'b0, 8'h00, 8'h55);
        s = stb0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
        end
        tests_run++; if (busy0 !== 1'b1) begin fails++; $display("FAIL rstmid_busy_before got %b want 1", busy0); end
        reset_n = 1'b0;
        #1;
        tests_run++; if (busy0 !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy0); end
        tests_run++; if (we0 !== 1'b0) begin fails++; $display("FAIL rstmid_wr_en got %b want 0", we0); end
        tests_run++; if (done0 !== 1'b0) begin fails++; $display("FAIL rstmid_done got %b want 0", done0); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        tests_run++; if (done0 !== 1'b0) begin fails++; $display("FAIL rstmid_no_done got %b want 0", done0); end
        tests_run++; if (stb0 != s) begin fails++; $display("FAIL rstmid_no_writes got %0d want 0", stb0 - s); end
        tests_run++; if (result(1'b0, 8'h00) !== 32'h55555555) begin fails++; $display("FAIL rstmid_bytes got %h want 55555555", result(1'b0, 8'h00)); end
        load_ops(1'b0, 8'h00, 16'h0007, 16'h0006);
        run_op(1'b0, de, wf, ns, b0);
        tests_run++; if (result(1'b0, 8'h00) !== 32'h0000002A) begin fails++; $display("FAIL rstmid_relaunch got %h want 0000002a", result(1'b0, 8'h00)); end
        tests_run++; if (de != DE) begin fails++; $display("FAIL rstmid_relaunch_latency got %0d want %0d", de, DE); end
    endtask

    task automatic test_abort;
        int de, wf, ns, s; logic b0;
        load_ops(1'b0, 8'h00, 16'h0102, 16'h0304);
        s = stb0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk); #1;
        end
        start0 = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (busy0 !== 1'b0) begin fails++; $display("FAIL abort_idle busy got %b want 0", busy0); end
        repeat (30) @(posedge clk);
        #1;
        tests_run++; if (done0 !== 1'b0) begin fails++; $display("FAIL abort_no_done got %b want 0", done0); end
        tests_run++; if (stb0 != s) begin fails++; $display("FAIL abort_no_writes got %0d want 0", stb0 - s); end
        tests_run++; if (result(1'b0, 8'h00) !== 32'h0000002A) begin fails++; $display("FAIL abort_bytes_kept got %h want 0000002a", result(1'b0, 8'h00)); end
        run_op(1'b0, de, wf, ns, b0);
        tests_run++; if (result(1'b0, 8'h00) !== 32'h00030A08) begin fails++; $display("FAIL abort_relaunch got %h want 00030a08", result(1'b0, 8'h00)); end
        tests_run++; if (de != DE) begin fails++; $display("FAIL abort_relaunch_latency got %0d want %0d", de, DE); end
    endtask

    task automatic test_wrap;
        int de, wf, ns, s; logic b0;
        load_ops(1'b1, 8'hFC, 16'hFFFF, 16'hFFFF);
        fill_res(1'b1, 8'hFC, 8'hAA);
        poke(1'b1, 8'h05, 8'h77);
        s = stb1;
        run_op(1'b1, de, wf, ns, b0);
        tests_run++; if (de != DE) begin fails++; $display("FAIL wrap_latency got %0d want %0d", de, DE); end
        tests_run++; if ({mem1[1], mem1[2], mem1[3], mem1[4]} !== 32'h00000001) begin fails++; $display("FAIL wrap_product got %h want 00000001", {mem1[1], mem1[2], mem1[3], mem1[4]}); end
        tests_run++; if (mem1[5] !== 8'h77) begin fails++; $display("FAIL wrap_neighbour got %h want 77", mem1[5]); end
        tests_run++; if (stb1 - s != 4) begin fails++; $display("FAIL wrap_strobes got %0d want 4", stb1 - s); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_zero();
        test_reset_mid();
        test_abort();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
